// File: rtl/handshake_pkg.sv
// Shared helpers for handshake dataflow nodes: counter width sizing and
// the ready/valid transfer condition.
package handshake_pkg;

  // Bits needed to hold an occupancy count in the range [0, depth].
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Handshake semantics used by every node: a token moves on a rising clock
  // edge exactly when valid and ready are both high in that cycle. A producer
  // that raises valid keeps it (and its payload) stable until the transfer.
  function automatic logic fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/handshake_token_counter.sv
// Occupancy counter for an elastic buffer whose tokens carry no data.
// Tracks how many tokens are held (0..DEPTH) and decodes full/empty from
// the registered count only.
module handshake_token_counter
  import handshake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  output logic [cnt_w(DEPTH)-1:0] o_cnt,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0] r_cnt;

  // Count up on push, down on pop; push and pop together cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_push && !i_pop) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !i_push) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);

  // The caller's ready/valid gating must keep the count inside [0, DEPTH].
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full && !i_pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(i_pop && o_empty));

endmodule

// File: rtl/handshake_constant_elastic.sv
// Elastic constant source: every token accepted on ctrl produces one token
// carrying a constant on outs, after at least one cycle of buffering in a
// DEPTH-slot occupancy counter. ctrl_ready is decoded from the registered
// count only, so there is no combinational path from outs_ready.
// Optional feature macro HANDSHAKE_CONSTANT_CFG_EN: adds a cfg ready/valid
// port that reloads the constant while the buffer is empty.
module handshake_constant_elastic
  import handshake_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned VALUE      = 3,
  parameter int          DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
`ifdef HANDSHAKE_CONSTANT_CFG_EN
  ,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_value
`endif
);

  localparam int                    CW      = cnt_w(DEPTH);
  localparam logic [DATA_WIDTH-1:0] C_VALUE = DATA_WIDTH'(VALUE);

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_cnt;

  handshake_token_counter #(
    .DEPTH(DEPTH)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .o_cnt  (w_cnt),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // A full buffer refuses input even when the consumer is draining this
  // cycle; the stall reaches upstream one cycle later.
  assign ctrl_ready = !rst && !w_full;
  assign outs_valid = !w_empty;
  assign w_push     = fire(ctrl_valid, ctrl_ready);
  assign w_pop      = fire(outs_valid, outs_ready);

`ifdef HANDSHAKE_CONSTANT_CFG_EN
  logic [DATA_WIDTH-1:0] r_value;
  logic                  w_load;

  // Reload only while nothing is buffered, so queued tokens keep their value.
  assign cfg_ready = !rst && w_empty;
  assign w_load    = fire(cfg_valid, cfg_ready);

  // Runtime constant; a push in the load cycle leaves after the edge and
  // therefore already carries the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= C_VALUE;
    end else if (w_load) begin
      r_value <= cfg_value;
    end
  end

  assign outs = r_value;
`else
  assign outs = C_VALUE;
`endif

  // Producers must hold ctrl_valid until their token is accepted.
  a_ctrl_hold: assert property (@(posedge clk) disable iff (rst) (ctrl_valid && !ctrl_ready) |=> ctrl_valid);
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) w_cnt <= CW'(DEPTH));

endmodule

// File: tb/tb_handshake_constant_elastic.sv
// Bench for handshake_constant_elastic: three instances (DEPTH 2, 1, 3 with
// different widths/constants), a vector table for the DEPTH=2 scenarios,
// a hand sequence for DEPTH=1 and a randomised model-checked run on DEPTH=3.
module tb_handshake_constant_elastic;

  localparam logic [31:0] C2 = 32'h0000_0003;  // DW=32, VALUE=3
  localparam logic [15:0] C1 = 16'h2345;       // DW=16, VALUE=0x12345 truncated
  localparam logic [7:0]  C3 = 8'h2C;          // DW=8,  VALUE=300 truncated

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        cv2 = 1'b0, cr2, ov2, or2 = 1'b0;
  logic [31:0] outs2;
  logic        cv1 = 1'b0, cr1, ov1, or1 = 1'b0;
  logic [15:0] outs1;
  logic        cv3 = 1'b0, cr3, ov3, or3 = 1'b0;
  logic [7:0]  outs3;
`ifdef HANDSHAKE_CONSTANT_CFG_EN
  logic        cfgv2 = 1'b0, cfgr2;
  logic [31:0] cfgd2 = '0;
  logic        cfgv1 = 1'b0, cfgr1;
  logic [15:0] cfgd1 = '0;
  logic        cfgv3 = 1'b0, cfgr3;
  logic [7:0]  cfgd3 = '0;
`endif

  handshake_constant_elastic #(.DATA_WIDTH(32), .VALUE(3), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .ctrl_valid(cv2), .ctrl_ready(cr2),
    .outs(outs2), .outs_valid(ov2), .outs_ready(or2)
`ifdef HANDSHAKE_CONSTANT_CFG_EN
    , .cfg_valid(cfgv2), .cfg_ready(cfgr2), .cfg_value(cfgd2)
`endif
  );

  handshake_constant_elastic #(.DATA_WIDTH(16), .VALUE(32'h12345), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .ctrl_valid(cv1), .ctrl_ready(cr1),
    .outs(outs1), .outs_valid(ov1), .outs_ready(or1)
`ifdef HANDSHAKE_CONSTANT_CFG_EN
    , .cfg_valid(cfgv1), .cfg_ready(cfgr1), .cfg_value(cfgd1)
`endif
  );

  handshake_constant_elastic #(.DATA_WIDTH(8), .VALUE(300), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .ctrl_valid(cv3), .ctrl_ready(cr3),
    .outs(outs3), .outs_valid(ov3), .outs_ready(or3)
`ifdef HANDSHAKE_CONSTANT_CFG_EN
    , .cfg_valid(cfgv3), .cfg_ready(cfgr3), .cfg_value(cfgd3)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_in  = 0;
  int n_out = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called when the DUT presents an output token that is being taken.
  task automatic sb_pop(input string name, input logic [31:0] act);
    n_out++;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got token %0h expected no token (t=%0t)", name, act, $time);
    end else begin
      chk(name, {32'h0, act}, {32'h0, exp_q.pop_front()});
    end
  endtask

  // ---------------- vector table (DEPTH=2) ----------------
  typedef struct {
    logic rst;
    logic cv;
    logic ordy;
    logic exp_cr;
    logic exp_ov;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic cv, input logic o,
                              input logic cr, input logic ov);
    vec_t v;
    v.rst = r; v.cv = cv; v.ordy = o; v.exp_cr = cr; v.exp_ov = ov;
    tbl.push_back(v);
  endfunction

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("d2[%0d]", idx);
    @(negedge clk);
    rst = v.rst;
    cv2 = v.cv;
    or2 = v.ordy;
    #1;
    chk({tag, ".ctrl_ready"}, {63'h0, cr2}, {63'h0, v.exp_cr});
    chk({tag, ".outs_valid"}, {63'h0, ov2}, {63'h0, v.exp_ov});
    chk({tag, ".outs"}, {32'h0, outs2}, {32'h0, C2});
    if (!v.rst && ov2 && v.ordy) sb_pop({tag, ".token"}, outs2);
    if (!v.rst && v.cv && v.exp_cr) begin
      exp_q.push_back(C2);
      n_in++;
    end
    @(posedge clk);
    if (v.rst) exp_q.delete();
  endtask

  // ---------------- DEPTH=3 model step ----------------
  int          cnt_m     = 0;
  logic        hold3     = 1'b0;
  logic [7:0]  exp_const3 = C3;

  task automatic step3(input logic cv, input logic o, input string tag);
    logic       exp_cr;
    logic       exp_ov;
    logic [7:0] push_val;
    logic       load;
    @(negedge clk);
    cv3 = cv;
    or3 = o;
    #1;
    exp_cr   = (cnt_m < 3);
    exp_ov   = (cnt_m != 0);
    push_val = exp_const3;
    load     = 1'b0;
    chk({tag, ".ctrl_ready"}, {63'h0, cr3}, {63'h0, exp_cr});
    chk({tag, ".outs_valid"}, {63'h0, ov3}, {63'h0, exp_ov});
    chk({tag, ".outs"}, {56'h0, outs3}, {56'h0, exp_const3});
`ifdef HANDSHAKE_CONSTANT_CFG_EN
    chk({tag, ".cfg_ready"}, {63'h0, cfgr3}, {63'h0, (cnt_m == 0)});
    load = cfgv3 && (cnt_m == 0);
    if (load) push_val = cfgd3;
`endif
    if (ov3 && o) sb_pop({tag, ".token"}, {24'h0, outs3});
    if (cv && exp_cr) begin
      exp_q.push_back({24'h0, push_val});
      n_in++;
    end
    hold3 = cv && !exp_cr;
    cnt_m = cnt_m + ((cv && exp_cr) ? 1 : 0) - ((exp_ov && o) ? 1 : 0);
    @(posedge clk);
    if (load) exp_const3 = push_val;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc1;
    int pop1;

    // Reset: a single unchecked edge clears the X count, then vectors check.
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0);
    // Full-rate stream: 8 ctrl tokens with outs_ready high, then drain.
    add(0, 1, 1, 1, 0);
    for (int k = 0; k < 7; k++) add(0, 1, 1, 1, 1);
    add(0, 0, 1, 1, 1);
    add(0, 0, 1, 1, 0);
    // Back-pressure: fill to DEPTH, stall, no push-on-pop when full.
    add(0, 1, 0, 1, 0);
    add(0, 1, 0, 1, 1);
    add(0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 1);
    add(0, 1, 1, 1, 1);
    add(0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 0);
    // Reset mid-operation with two tokens buffered; push right after.
    add(0, 1, 0, 1, 0);
    add(0, 1, 0, 1, 1);
    add(1, 1, 0, 0, 1);
    add(0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 0);

    rst = 1'b1;
    @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_vec(tbl[i], i);
      if (i == 12) begin
        chk("d2.stream_tokens_out", 64'(n_out), 64'd8);
        chk("d2.stream_tokens_in", 64'(n_in), 64'd8);
      end
    end
    @(negedge clk);
    cv2 = 1'b0;
    or2 = 1'b0;
    chk("d2.sb_left", 64'(exp_q.size()), 64'd0);

    // DEPTH=1: both sides always active gives one token every two cycles.
    acc1 = 0;
    pop1 = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cv1 = 1'b1;
      or1 = 1'b1;
      #1;
      chk($sformatf("d1[%0d].ctrl_ready", i), {63'h0, cr1}, {63'h0, (i % 2 == 0)});
      chk($sformatf("d1[%0d].outs_valid", i), {63'h0, ov1}, {63'h0, (i % 2 == 1)});
      chk($sformatf("d1[%0d].outs", i), {48'h0, outs1}, {48'h0, C1});
      if (cv1 && cr1) acc1++;
      if (ov1 && or1) pop1++;
    end
    chk("d1.tokens_in", 64'(acc1), 64'd6);
    chk("d1.tokens_out", 64'(pop1), 64'd5);
    @(negedge clk);
    cv1 = 1'b0;
    or1 = 1'b1;
    #1;
    chk("d1.drain_valid", {63'h0, ov1}, 64'd1);
    @(negedge clk);
    or1 = 1'b0;
    #1;
    chk("d1.empty_valid", {63'h0, ov1}, 64'd0);

    // DEPTH=3: random valid/ready with held valid, alternating load phases.
    exp_q.delete();
    n_in  = 0;
    n_out = 0;
    for (int i = 0; i < 10000; i++) begin
      logic cv;
      logic o;
      cv = hold3 ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (((i / 500) % 2) == 0) o = ($urandom_range(0, 3) == 0);
      else                      o = ($urandom_range(0, 3) != 0);
      step3(cv, o, "d3.rand");
    end
    chk("d3.conservation", 64'(n_in), 64'(n_out + cnt_m));

    // Drain DEPTH=3, bounded.
    for (int i = 0; i < 20; i++) begin
      if (cnt_m == 0 && !hold3) break;
      step3(hold3, 1'b1, "d3.drain");
    end
    chk("d3.drained_count", 64'(cnt_m), 64'd0);
    chk("d3.sb_left", 64'(exp_q.size()), 64'd0);

`ifdef HANDSHAKE_CONSTANT_CFG_EN
    // Runtime reload: refused while a token is buffered, accepted once empty.
    step3(1'b1, 1'b0, "cfg.push");
    cfgv3 = 1'b1;
    cfgd3 = 8'hA5;
    step3(1'b0, 1'b0, "cfg.busy");
    chk("cfg.busy_ready", {63'h0, cfgr3}, 64'd0);
    step3(1'b0, 1'b1, "cfg.drain");
    step3(1'b1, 1'b0, "cfg.load_push");
    cfgv3 = 1'b0;
    step3(1'b0, 1'b1, "cfg.new_token");
    chk("cfg.new_value", {56'h0, outs3}, 64'hA5);
    step3(1'b1, 1'b1, "cfg.again");
    step3(1'b0, 1'b1, "cfg.again_drain");
    @(negedge clk);
    rst = 1'b1;
    cv3 = 1'b0;
    or3 = 1'b0;
    #1;
    chk("cfg.rst_ready", {63'h0, cfgr3}, 64'd0);
    @(posedge clk);
    exp_q.delete();
    cnt_m      = 0;
    hold3      = 1'b0;
    exp_const3 = C3;
    @(negedge clk);
    rst = 1'b0;
    step3(1'b0, 1'b0, "cfg.after_rst");
    chk("cfg.restored", {56'h0, outs3}, {56'h0, C3});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
